fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 20 ++
 rtl/fetch_buffer.sv | 76 +++++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Imported by fetch_unit and fetch_buffer.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_FULL   = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_t;

    localparam logic READ  = 1'b0;
    localparam logic WRITE = 1'b1;

    localparam logic [31:0] DEFAULT_STARTING_ADDR = 32'h0100_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Circular instruction buffer holding {pc, inst} entries.
// Head output reads as zero whenever the buffer is empty.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  logic [63:0] data_i,
    output logic [63:0] head_o,
    output logic        valid_o,
    output logic [3:0]  count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i && (cnt_q != 4'd0);
    assign do_push = push_i && ((cnt_q != 4'(DEPTH)) || do_pop);

    // Pointer and occupancy next-state; flush overrides push and pop
    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = 4'd0;
        end else begin
            if (do_pop)  rd_d = bump(rd_q);
            if (do_push) wr_d = bump(wr_q);
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 4'd1;
                2'b01:   cnt_d = cnt_q - 4'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= 4'd0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; stale contents are masked by valid_o
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign valid_o = (cnt_q != 4'd0);
    assign head_o  = valid_o ? mem_q[rd_q] : 64'h0;
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC, fetch FSM and capture counter.
// Captured words are queued in fetch_buffer for the decoder.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] STARTING_ADDR = DEFAULT_STARTING_ADDR,
    parameter int          DEPTH         = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    input  logic        inst_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] fetch_count
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         capture, pop, flush;
    logic [3:0]   occ, occ_nxt;
    logic [63:0]  head;

    fetch_buffer #(.DEPTH(DEPTH)) u_buf (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (capture),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  ({pc_q, mem_data_out}),
        .head_o  (head),
        .valid_o (inst_valid),
        .count_o (occ)
    );

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= ST_FETCH;
        else       state_q <= state_d;
    end

    // FSM next state: redirect beats halt beats normal flow
    always_comb begin
        state_d = state_q;
        occ_nxt = occ + {3'b000, capture} - {3'b000, pop};
        if (redirect_valid) begin
            state_d = halt ? ST_HALTED : ST_FETCH;
        end else if (halt) begin
            state_d = ST_HALTED;
        end else begin
            unique case (state_q)
                ST_FETCH:  state_d = (occ_nxt == 4'(DEPTH)) ? ST_FULL : ST_FETCH;
                ST_FULL:   state_d = pop ? ST_FETCH : ST_FULL;
                ST_HALTED: state_d = ST_FETCH;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    // FSM outputs: buffer push, pop and flush strobes
    always_comb begin
        flush   = redirect_valid;
        pop     = 1'b0;
        capture = 1'b0;
        if (!redirect_valid) begin
            pop     = inst_valid && inst_ready;
            capture = (state_q == ST_FETCH) && !halt
                      && ((occ < 4'(DEPTH)) || pop);
        end
    end

    // PC and capture counter next state
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end else if (capture) begin
            pc_d  = pc_q + 32'd4;
            cnt_d = cnt_q + 32'd1;
        end
    end

    // PC and capture counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q  <= STARTING_ADDR;
            cnt_q <= 32'd0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign mem_address    = pc_q;
    assign mem_read_write = READ;
    assign mem_data_in    = 32'h0;
    assign inst           = head[31:0];
    assign inst_pc        = head[63:32];
    assign fetch_count    = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus
// randomised traffic compared against a queue-based model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] START = 32'h0100_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_address;
    logic        mem_read_write;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        inst_ready;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] fetch_count;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0100_0000: return 32'h0000_0013;
            32'h0100_0004: return 32'h0010_0093;
            32'h0100_0008: return 32'h0020_0113;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    assign mem_data_out = mem_word(mem_address);

    fetch_unit #(.STARTING_ADDR(START), .DEPTH(DEPTH)) dut (
        .clock          (clock),
        .reset          (reset),
        .mem_address    (mem_address),
        .mem_read_write (mem_read_write),
        .mem_data_in    (mem_data_in),
        .mem_data_out   (mem_data_out),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .inst_ready     (inst_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fetch_count    (fetch_count)
    );

    logic [63:0] mq[$];
    logic [31:0] m_pc  = START;
    logic [31:0] m_cnt = 32'd0;
    bit          m_halted = 1'b0;
    bit          m_full   = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, word} plus halted/full flags
    always @(posedge clock or posedge reset) begin
        bit pop, cap;
        if (reset) begin
            mq.delete();
            m_pc     = START;
            m_cnt    = 32'd0;
            m_halted = 1'b0;
            m_full   = 1'b0;
        end else begin
            pop = (mq.size() != 0) && inst_ready;
            if (redirect_valid) begin
                mq.delete();
                m_pc     = {redirect_pc[31:2], 2'b00};
                m_halted = halt;
                m_full   = 1'b0;
            end else if (halt) begin
                if (pop) void'(mq.pop_front());
                m_halted = 1'b1;
                m_full   = 1'b0;
            end else begin
                cap = !m_halted && !m_full && ((mq.size() < DEPTH) || pop);
                if (pop) void'(mq.pop_front());
                if (cap) begin
                    mq.push_back({m_pc, mem_word(m_pc)});
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
                if (m_halted)    m_halted = 1'b0;
                else if (m_full) m_full = !pop;
                else             m_full = (mq.size() == DEPTH);
            end
        end
    end

    // Compare every cycle on the falling edge
    always @(negedge clock) begin
        logic [31:0] e_inst, e_pc;
        if (chk_en) begin
            e_inst = 32'h0;
            e_pc   = 32'h0;
            if (mq.size() != 0) begin
                e_pc   = mq[0][63:32];
                e_inst = mq[0][31:0];
            end
            check("mem_address", mem_address, m_pc);
            check("inst_valid", {31'b0, inst_valid}, {31'b0, mq.size() != 0});
            check("inst", inst, e_inst);
            check("inst_pc", inst_pc, e_pc);
            check("fetch_count", fetch_count, m_cnt);
            check("mem_read_write", {31'b0, mem_read_write}, 32'h0);
            check("mem_data_in", mem_data_in, 32'h0);
        end
    end

    initial begin
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt           = 1'b0;
        inst_ready     = 1'b1;
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_addr", mem_address, 32'h0100_0000);
        check("rst_valid", {31'b0, inst_valid}, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", inst_pc, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        reset = 1'b0;

        // streaming after reset release
        @(negedge clock);
        check("s0_pc", inst_pc, 32'h0100_0000);
        check("s0_inst", inst, 32'h0000_0013);
        @(negedge clock);
        check("s1_pc", inst_pc, 32'h0100_0004);
        check("s1_inst", inst, 32'h0010_0093);
        @(negedge clock);
        check("s2_pc", inst_pc, 32'h0100_0008);
        check("s2_inst", inst, 32'h0020_0113);
        check("s2_count", fetch_count, 32'd3);

        // backpressure fills the buffer
        #1 reset = 1'b1;
        inst_ready = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        repeat (5) @(negedge clock);
        check("bp_addr", mem_address, 32'h0100_0008);
        check("bp_count", fetch_count, 32'd2);
        check("bp_pc", inst_pc, 32'h0100_0000);
        #1 inst_ready = 1'b1;
        @(negedge clock);
        check("bp_rel0", inst_pc, 32'h0100_0004);
        @(negedge clock);
        check("bp_rel1", inst_pc, 32'h0100_0008);
        check("bp_rel_cnt", fetch_count, 32'd3);

        // redirect with a full buffer
        #1 inst_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("rd_full_cnt", fetch_count, 32'd4);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0100_0043;
        inst_ready     = 1'b1;
        @(negedge clock);
        #1 redirect_valid = 1'b0;
        check("rd_valid", {31'b0, inst_valid}, 32'h0);
        check("rd_addr", mem_address, 32'h0100_0040);
        @(negedge clock);
        check("rd_pc", inst_pc, 32'h0100_0040);
        check("rd_cnt", fetch_count, 32'd5);

        // halt drains the buffer and freezes the PC
        #1 inst_ready = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        halt       = 1'b1;
        inst_ready = 1'b1;
        repeat (3) @(negedge clock);
        check("h_valid", {31'b0, inst_valid}, 32'h0);
        check("h_addr", mem_address, 32'h0100_0048);
        check("h_cnt", fetch_count, 32'd6);
        #1 halt = 1'b0;
        repeat (2) @(negedge clock);
        check("h_resume", inst_pc, 32'h0100_0048);
        check("h_rcnt", fetch_count, 32'd7);

        // PC wraps at the top of the address space
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clock);
        #1 redirect_valid = 1'b0;
        check("w_addr", mem_address, 32'hFFFF_FFFC);
        @(negedge clock);
        check("w_pc0", inst_pc, 32'hFFFF_FFFC);
        @(negedge clock);
        check("w_pc1", inst_pc, 32'h0000_0000);
        check("w_addr1", mem_address, 32'h0000_0004);

        // asynchronous reset in mid-cycle
        #1 inst_ready = 1'b0;
        repeat (2) @(negedge clock);
        check("ar_pre", {31'b0, inst_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("ar_valid", {31'b0, inst_valid}, 32'h0);
        check("ar_addr", mem_address, 32'h0100_0000);
        check("ar_cnt", fetch_count, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            #1;
            inst_ready     = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 19) == 0) halt = ~halt;
            redirect_valid = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 3) == 0)
                redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            else
                redirect_pc = $urandom;
            reset = ($urandom_range(0, 199) == 0);
        end
        @(negedge clock);
        #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt           = 1'b0;
        repeat (3) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
